// File: rtl/pipo_load_arbiter.sv
// pipo_load_arbiter: round-robin arbiter that grants one requester at a time
// access to a shared parallel-load register. Each transaction is
// IDLE -> LOAD -> ACK -> GAP(HOLDOFF cycles) -> IDLE. Requests are only looked
// at in IDLE. The winner's data is captured at the grant edge, so later changes
// on i_DATA/i_REQ cannot disturb a load that is already in flight.
module pipo_load_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 8,
  parameter int HOLDOFF = 2
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic [N_REQ-1:0]   i_REQ,
  input  logic [N_REQ*W-1:0] i_DATA,
  output logic [N_REQ-1:0]   o_GNT,
  output logic               o_LOAD,
  output logic [W-1:0]       o_DATA,
  output logic [N_REQ-1:0]   o_ACK,
  output logic               o_BUSY
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);
  // GAP counts down from HOLDOFF-1 to 0, giving exactly HOLDOFF GAP cycles.
  localparam logic [3:0] CNT_INIT = (HOLDOFF > 0) ? 4'(HOLDOFF - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACK  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               load_q, load_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [W-1:0]       data_q, data_d;
  logic               busy_q, busy_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      win_q, win_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [PW-1:0]      pick_s;

  // First set request bit at or above ptr, wrapping from N_REQ-1 back to 0.
  function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [PW-1:0]    ptr);
    logic [PW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
    return pick;
  endfunction

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    load_d  = 1'b0;
    ack_d   = '0;
    data_d  = data_q;
    busy_d  = 1'b1;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    pick_s  = rr_pick(i_REQ, ptr_q);
    case (state_q)
      ST_IDLE: begin
        if (|i_REQ) begin
          win_d         = pick_s;
          gnt_d         = '0;
          gnt_d[pick_s] = 1'b1;
          data_d        = i_DATA[pick_s*W +: W];
          load_d        = 1'b1;
          state_d       = ST_LOAD;
        end else begin
          gnt_d  = '0;
          busy_d = 1'b0;
        end
      end
      ST_LOAD: begin
        // Grant and data are held; the ACK pulse goes to the current grantee.
        ack_d   = gnt_q;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        gnt_d = '0;
        ptr_d = (win_q == LAST_IDX) ? '0 : (win_q + PW'(1));
        if (HOLDOFF > 0) begin
          state_d = ST_GAP;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_GAP: begin
        gnt_d = '0;
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      load_q  <= 1'b0;
      ack_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      load_q  <= load_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_GNT  = gnt_q;
  assign o_LOAD = load_q;
  assign o_ACK  = ack_q;
  assign o_DATA = data_q;
  assign o_BUSY = busy_q;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Scoreboard bench for pipo_load_arbiter (N_REQ=4, W=8, HOLDOFF=2).
// Expected grants are queued when stimulus is driven; a negedge monitor pops
// them on every o_LOAD and checks the ACK that must follow one cycle later.
module tb_pipo_load_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [W-1:0] data;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic           load;
  logic [W-1:0]   dout;
  logic [N-1:0]   ack;
  logic           busy;

  exp_t         sb_q[$];
  int           n_checks;
  int           n_err;
  int           cyc;
  int           last_load_cyc;
  bit           load_valid;
  bit           period_chk;
  bit           rst_at_edge;
  logic [N-1:0] ack_exp;

  pipo_load_arbiter #(.N_REQ(N), .W(W), .HOLDOFF(2)) dut (
    .i_CLK  (clk),
    .i_RST  (rst),
    .i_REQ  (req),
    .i_DATA (din),
    .o_GNT  (gnt),
    .o_LOAD (load),
    .o_DATA (dout),
    .o_ACK  (ack),
    .o_BUSY (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_data(input int k, input logic [W-1:0] v);
    din[k*W +: W] = v;
  endtask

  task automatic push_exp(input logic [N-1:0] g, input logic [W-1:0] d);
    exp_t e;
    e.gnt  = g;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 100 && sb_q.size() != 0; c++) tick(1);
    check_eq(tag, sb_q.size(), 0);
  endtask

  // Cycle counter and record of whether reset was applied at this edge.
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  // Monitor: pop the scoreboard on each load, then demand the matching ACK.
  always @(negedge clk) begin
    exp_t e;
    if (rst_at_edge) begin
      ack_exp    = '0;
      load_valid = 1'b0;
    end else begin
      if (ack != '0 || ack_exp != '0) check_eq("ack", ack, ack_exp);
      ack_exp = '0;
      if (load) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_load", gnt, 0);
        end else begin
          e = sb_q.pop_front();
          check_eq("load_gnt", gnt, e.gnt);
          check_eq("load_data", dout, e.data);
          ack_exp = e.gnt;
          if (period_chk && load_valid) check_eq("load_period", cyc - last_load_cyc, 5);
          last_load_cyc = cyc;
          load_valid    = 1'b1;
        end
      end
    end
  end

  initial begin
    n_checks = 0; n_err = 0; cyc = 0; last_load_cyc = 0;
    load_valid = 1'b0; period_chk = 1'b0; ack_exp = '0;
    rst = 1'b1; req = '0; din = '0;
    tick(3);
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_load", load, 0);
    check_eq("rst_ack", ack, 0);
    check_eq("rst_data", dout, 0);
    check_eq("rst_busy", busy, 0);

    // Single request from requester 0.
    rst = 1'b0;
    set_data(0, 8'hA5);
    req = 4'b0001;
    push_exp(4'b0001, 8'hA5);
    tick(1);
    check_eq("s1_load", load, 1);
    check_eq("s1_busy_load", busy, 1);
    req = '0;
    tick(1);
    check_eq("s1_load_off", load, 0);
    check_eq("s1_gnt_ack", gnt, 4'b0001);
    tick(1);
    check_eq("s1_gap_gnt", gnt, 0);
    check_eq("s1_gap_busy", busy, 1);
    tick(1);
    check_eq("s1_gap2_busy", busy, 1);
    tick(1);
    check_eq("s1_idle_busy", busy, 0);
    check_eq("s1_data_held", dout, 8'hA5);
    tick(2);

    // All four request continuously after reset: 0,1,2,3,0 five cycles apart.
    rst = 1'b1;
    tick(2);
    for (int k = 0; k < N; k++) set_data(k, 8'(8'h10 + k));
    push_exp(4'b0001, 8'h10);
    push_exp(4'b0010, 8'h11);
    push_exp(4'b0100, 8'h12);
    push_exp(4'b1000, 8'h13);
    push_exp(4'b0001, 8'h10);
    period_chk = 1'b1;
    rst = 1'b0;
    req = 4'b1111;
    drain("s2_drain");
    req = '0;
    tick(6);
    period_chk = 1'b0;

    // Serve requester 2 (ptr -> 3), then 1001 grants 3 then wraps to 0.
    req = 4'b0100;
    push_exp(4'b0100, 8'h12);
    drain("s3a_drain");
    req = '0;
    tick(6);
    req = 4'b1001;
    push_exp(4'b1000, 8'h13);
    push_exp(4'b0001, 8'h10);
    drain("s3b_drain");
    req = '0;
    tick(6);

    // Data changes after grant must not affect the loaded value.
    set_data(1, 8'h3C);
    req = 4'b0010;
    push_exp(4'b0010, 8'h3C);
    tick(1);
    set_data(1, 8'hFF);
    req = '0;
    tick(1);
    check_eq("s4_data_ack", dout, 8'h3C);
    tick(5);
    check_eq("s4_data_idle", dout, 8'h3C);

    // Reset in LOAD aborts; afterwards requester 2 is granted from ptr=0.
    set_data(0, 8'h5A);
    req = 4'b0001;
    push_exp(4'b0001, 8'h5A);
    tick(1);
    check_eq("s5_in_load", load, 1);
    rst = 1'b1;
    req = '0;
    tick(1);
    check_eq("s5_rst_gnt", gnt, 0);
    check_eq("s5_rst_load", load, 0);
    check_eq("s5_rst_ack", ack, 0);
    check_eq("s5_rst_data", dout, 0);
    check_eq("s5_rst_busy", busy, 0);
    rst = 1'b0;
    set_data(2, 8'h77);
    req = 4'b0100;
    push_exp(4'b0100, 8'h77);
    drain("s5_drain");
    req = '0;
    tick(6);

    // A request held only during GAP is ignored.
    req = 4'b0001;
    push_exp(4'b0001, 8'h5A);
    tick(1);
    req = '0;
    tick(2);
    check_eq("s6_in_gap", busy, 1);
    req = 4'b0100;
    tick(1);
    req = '0;
    tick(8);
    check_eq("s6_no_gnt", gnt, 0);
    check_eq("s6_idle", busy, 0);
    check_eq("s6_data", dout, 8'h5A);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
